// File: rtl/student_circuit_pipe.sv
// rtl/student_circuit_pipe.sv - delay-line XOR pipe with valid handshake and fill indicator
// Optional STUDENT_CCT_PRIMED_GATE_EN: suppress out_valid until the delay line is primed.
module student_circuit_pipe #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 2,
  parameter int ADD_CONST = 17,
  parameter int RESET_VAL = 3
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             sclr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] cct_input,
  output logic             out_valid,
  output logic [WIDTH-1:0] cct_output,
  output logic             primed
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [WIDTH-1:0] ADD_V = WIDTH'(ADD_CONST);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);
  localparam logic [CW-1:0]    FULL  = CW'(DEPTH);
  localparam logic [DEPTH-1:0][WIDTH-1:0] STAGE_RST = {{((DEPTH-1)*WIDTH){1'b0}}, RST_V};

  // Index 0 holds the newest sample (stage 1), index DEPTH-1 the oldest.
  logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
  logic [CW-1:0]               count_q, count_d;
  logic [WIDTH-1:0]            result_q, result_d;
  logic                        valid_q, valid_d;
  logic                        primed_q, primed_d;

  always_comb begin
    stage_d  = stage_q;
    count_d  = count_q;
    result_d = result_q;
    valid_d  = 1'b0;
    primed_d = primed_q;
    if (sclr) begin
      stage_d  = STAGE_RST;
      count_d  = '0;
      result_d = '0;
      primed_d = 1'b0;
    end else if (in_valid) begin
      result_d = stage_q[DEPTH-1] ^ stage_q[0] ^ (cct_input + ADD_V);
`ifdef STUDENT_CCT_PRIMED_GATE_EN
      valid_d  = primed_q;
`else
      valid_d  = 1'b1;
`endif
      stage_d  = {stage_q[DEPTH-2:0], cct_input};
      if (count_q != FULL) begin
        count_d = count_q + CW'(1);
      end
      primed_d = (count_d == FULL);
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      stage_q  <= STAGE_RST;
      count_q  <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      stage_q  <= stage_d;
      count_q  <= count_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      primed_q <= primed_d;
    end
  end

  assign cct_output = result_q;
  assign out_valid  = valid_q;
  assign primed     = primed_q;

endmodule

// File: tb/tb_student_circuit_pipe.sv
// tb/tb_student_circuit_pipe.sv - table-driven checks for student_circuit_pipe at default parameters
module tb_student_circuit_pipe;

`ifdef STUDENT_CCT_PRIMED_GATE_EN
  localparam bit GATED = 1'b1;
`else
  localparam bit GATED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clear_n;
  logic       sclr;
  logic       in_valid;
  logic [7:0] cct_input;
  logic       out_valid;
  logic [7:0] cct_output;
  logic       primed;

  int n_tests = 0;
  int n_fail  = 0;

  student_circuit_pipe #(
    .WIDTH(8), .DEPTH(2), .ADD_CONST(17), .RESET_VAL(3)
  ) dut (
    .clk(clk), .clear_n(clear_n), .sclr(sclr), .in_valid(in_valid),
    .cct_input(cct_input), .out_valid(out_valid), .cct_output(cct_output),
    .primed(primed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sclr;
    logic       vld;
    logic [7:0] din;
    logic [7:0] exp_out;
    logic       exp_v;
    logic       exp_vg;
    logic       exp_p;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic v, input logic [7:0] d);
    sclr      = s;
    in_valid  = v;
    cct_input = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // sclr, vld, din, exp_out, exp_v, exp_vg, exp_p
    vecs[0]  = '{1'b0, 1'b1, 8'h10, 8'h22, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'h20, 8'h22, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 8'h30, 8'h71, 1'b1, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 8'h71, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 8'h55, 8'h71, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 8'h71, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 8'h05, 8'h06, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'h00, 8'h12, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'hF0, 8'h02, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 8'hFF, 8'hE0, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 8'h10, 8'h22, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 8'h22, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 8'h22, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 8'h22, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 8'h20, 8'h22, 1'b1, 1'b0, 1'b1};

    clear_n   = 1'b0;
    sclr      = 1'b0;
    in_valid  = 1'b0;
    cct_input = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out", cct_output, 8'h00);
    chk("reset valid", {7'd0, out_valid}, 8'h00);
    chk("reset primed", {7'd0, primed}, 8'h00);
    clear_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].sclr, vecs[i].vld, vecs[i].din);
      chk($sformatf("row%0d out", i), cct_output, vecs[i].exp_out);
      chk($sformatf("row%0d valid", i), {7'd0, out_valid},
          {7'd0, (GATED ? vecs[i].exp_vg : vecs[i].exp_v)});
      chk($sformatf("row%0d primed", i), {7'd0, primed}, {7'd0, vecs[i].exp_p});
    end

    // Asynchronous clear between edges, then first accept right after release.
    sclr     = 1'b0;
    in_valid = 1'b0;
    #2;
    clear_n = 1'b0;
    #1;
    chk("async out", cct_output, 8'h00);
    chk("async valid", {7'd0, out_valid}, 8'h00);
    chk("async primed", {7'd0, primed}, 8'h00);
    #1;
    clear_n = 1'b1;
    step(1'b0, 1'b1, 8'hF0);
    chk("post-clear out", cct_output, 8'h02);
    chk("post-clear valid", {7'd0, out_valid}, {7'd0, !GATED});
    chk("post-clear primed", {7'd0, primed}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
